encoding_cont: RTL



---
 rtl/rs_pkg.sv | 41 ++++
 rtl/encoding_cont_gf16_mul.sv | 11 +
 rtl/encoding_cont.sv | 81 ++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// RS(15,9) over GF(16) shared constants and helpers.
// Used by both the encoder and decodingCont.
package rs_pkg;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int K     = 9;
  localparam int NPAR  = 6;

  // x^4 = x + 1 under x^4+x+1
  localparam logic [3:0] PRIM_POLY = 4'b0011;

  // g(x) = prod (x + a^i), i=1..6, low order first
  localparam logic [3:0] GEN [0:6] = '{
    4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7, 4'h1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } encState_t;

  // Shift-and-add product, reduced on each overflow of x^3
  function automatic logic [3:0] gf16_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] acc;
    logic [3:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ x;
      if (x[3]) x = {x[2:0], 1'b0} ^ PRIM_POLY;
      else      x = {x[2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/encoding_cont_gf16_mul.sv
// Combinational GF(16) multiplier.
// One instance per generator tap in the encoder LFSR.
module gf16_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  assign p = rs_pkg::gf16_mul(a, b);

endmodule

// File: rtl/encoding_cont.sv
// Systematic RS(15,9) encoder, one message symbol per clock.
// Output packing matches the decoder's received-word input.
module encoding_cont
  import rs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] messageIn,
  input  logic        encodeMessage,
  output logic        encoderBusy,
  output logic [59:0] codewordOut,
  output logic        codewordValid
);

  encState_t             state;
  logic [35:0]           msgReg;
  logic [NPAR-1:0][3:0]  par;
  logic [3:0]            symCnt;
  logic [3:0]            curSym;
  logic [3:0]            fb;
  logic [NPAR-1:0][3:0]  prod;

  // Select the message symbol addressed by symCnt
  always_comb begin
    curSym = '0;
    for (int j = 0; j < K; j++) begin
      if (symCnt == j[3:0]) curSym = msgReg[4*j +: 4];
    end
  end

  assign fb = curSym ^ par[NPAR-1];

  for (genvar k = 0; k < NPAR; k++) begin : gTap
    gf16_mul uMul (
      .a (fb),
      .b (GEN[k]),
      .p (prod[k])
    );
  end

  assign encoderBusy = (state != IDLE);

  // Encoder FSM and parity LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      msgReg        <= '0;
      par           <= '0;
      symCnt        <= '0;
      codewordOut   <= '0;
      codewordValid <= 1'b0;
    end else begin
      codewordValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (encodeMessage) begin
            msgReg <= messageIn;
            par    <= '0;
            symCnt <= 4'd8;
            state  <= ENC;
          end
        end
        ENC: begin
          par[0] <= prod[0];
          for (int k = 1; k < NPAR; k++) begin
            par[k] <= par[k-1] ^ prod[k];
          end
          symCnt <= symCnt - 4'd1;
          if (symCnt == 4'd0) state <= DONE;
        end
        DONE: begin
          codewordOut   <= {msgReg, par};
          codewordValid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
